// File: rtl/clk_div_cfg_arb.sv
// ---------------------------------------------------------------------------
// clk_div_cfg_arb
//
// Round-robin arbiter that funnels divider-change requests from several
// masters (power manager, SW register file, DVFS controller) onto the single
// valid/ready configuration port of the integer clock divider. The winning
// value is held on div_o until the divider accepts it, after which the
// winning requester receives a one-cycle acknowledge.
//
// Optional feature (compile-time macro):
//   CLK_DIV_CFG_ARB_SKIP_SAME_EN - when defined, a granted request whose
//   normalized value equals the currently applied value is acknowledged
//   directly, without a divider handshake.
//
// Ports:
//   clk_i        in   clock
//   rst_ni       in   asynchronous active-low reset
//   req_valid_i  in   per-requester valid, held until its req_ready_o
//   req_div_i    in   per-requester divider value, slice i = requester i
//   req_ready_o  out  one-cycle acknowledge to the granted requester
//   div_o        out  value forwarded to the divider
//   div_valid_o  out  valid to the divider
//   div_ready_i  in   ready from the divider
//   cur_div_o    out  last applied (normalized) divider value
//   busy_o       out  high whenever the arbiter is not idle
//   stall_o      out  the divider handshake has waited STALL_CYCLES cycles
// ---------------------------------------------------------------------------
module clk_div_cfg_arb #(
    parameter int NUM_REQ           = 2,
    parameter int DIV_VALUE_WIDTH   = 4,
    parameter int DEFAULT_DIV_VALUE = 1,
    parameter int STALL_CYCLES      = 64
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [NUM_REQ-1:0]                 req_valid_i,
    input  logic [NUM_REQ*DIV_VALUE_WIDTH-1:0] req_div_i,
    output logic [NUM_REQ-1:0]                 req_ready_o,
    output logic [DIV_VALUE_WIDTH-1:0]         div_o,
    output logic                               div_valid_o,
    input  logic                               div_ready_i,
    output logic [DIV_VALUE_WIDTH-1:0]         cur_div_o,
    output logic                               busy_o,
    output logic                               stall_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (STALL_CYCLES > 0) ? $clog2(STALL_CYCLES + 1) : 1;

    // A divide-by-0 request means divide-by-1, including the reset default.
    localparam logic [DIV_VALUE_WIDTH-1:0] DEFAULT_NORM =
        (DEFAULT_DIV_VALUE == 0) ? DIV_VALUE_WIDTH'(1) : DIV_VALUE_WIDTH'(DEFAULT_DIV_VALUE);
    localparam logic [CNT_W-1:0] STALL_MAX = CNT_W'(STALL_CYCLES);
    localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_REQ - 1);
    localparam logic [PTR_W:0]   NUM_REQ_W = (PTR_W + 1)'(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        ACK
    } state_e;

    state_e                     state_q;
    state_e                     state_d;
    logic [PTR_W-1:0]           ptr_q;
    logic [PTR_W-1:0]           grant_q;
    logic [DIV_VALUE_WIDTH-1:0] val_q;
    logic [DIV_VALUE_WIDTH-1:0] cur_q;
    logic [CNT_W-1:0]           stall_cnt_q;

    logic [DIV_VALUE_WIDTH-1:0] req_div_arr [NUM_REQ];
    logic                       arb_found;
    logic [PTR_W-1:0]           arb_idx;
    logic [PTR_W:0]             arb_sum;
    logic [DIV_VALUE_WIDTH-1:0] arb_val;
    logic [DIV_VALUE_WIDTH-1:0] arb_val_n;
    logic                       skip_same;

    // Unpack the flat request bus into one value per requester.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_div_arr[i] = req_div_i[i*DIV_VALUE_WIDTH +: DIV_VALUE_WIDTH];
        end
    end

    // Round-robin search: first valid requester at or after the pointer,
    // wrapping. The sum stays below 2*NUM_REQ, so one subtraction wraps it.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        arb_sum   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            arb_sum = {1'b0, ptr_q} + (PTR_W + 1)'(i);
            if (arb_sum >= NUM_REQ_W) begin
                arb_sum = arb_sum - NUM_REQ_W;
            end
            if (!arb_found && req_valid_i[arb_sum[PTR_W-1:0]]) begin
                arb_found = 1'b1;
                arb_idx   = arb_sum[PTR_W-1:0];
            end
        end
    end

    assign arb_val   = req_div_arr[arb_idx];
    assign arb_val_n = (arb_val == '0) ? DIV_VALUE_WIDTH'(1) : arb_val;

`ifdef CLK_DIV_CFG_ARB_SKIP_SAME_EN
    assign skip_same = (arb_val_n == cur_q);
`else
    assign skip_same = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Valids are ignored in ACK so a requester still
    // holding valid while it samples its ready is not granted twice.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (arb_found) state_d = skip_same ? ACK : ISSUE;
            ISSUE:   if (div_ready_i) state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic. div_o/div_valid_o come straight from registered state so
    // they cannot change while the divider is deciding whether to accept.
    always_comb begin
        div_valid_o = 1'b0;
        div_o       = '0;
        req_ready_o = '0;
        stall_o     = 1'b0;
        busy_o      = (state_q != IDLE);
        case (state_q)
            ISSUE: begin
                div_valid_o = 1'b1;
                div_o       = val_q;
                stall_o     = (STALL_CYCLES != 0) && (stall_cnt_q >= STALL_MAX);
            end
            ACK: begin
                req_ready_o[grant_q] = 1'b1;
            end
            default: ;
        endcase
    end

    assign cur_div_o = cur_q;

    // Grant/value latch, applied-value tracking, pointer and stall counter.
    // The counter is loaded with 1 on entry so it equals the number of the
    // ISSUE cycle currently in progress.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q       <= '0;
            grant_q     <= '0;
            val_q       <= '0;
            cur_q       <= DEFAULT_NORM;
            stall_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (arb_found) begin
                        grant_q     <= arb_idx;
                        val_q       <= arb_val_n;
                        stall_cnt_q <= skip_same ? '0 : CNT_W'(1);
                    end
                end
                ISSUE: begin
                    if (div_ready_i) begin
                        cur_q       <= val_q;
                        stall_cnt_q <= '0;
                    end else if (stall_cnt_q < STALL_MAX) begin
                        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
                    end
                end
                ACK: begin
                    ptr_q <= (grant_q == LAST_IDX) ? '0 : grant_q + PTR_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
